// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve slice: RV32I branch funct3 codes
// and the resolve FSM state encoding.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DECIDE   = 2'd1,
    S_REDIRECT = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode: maps funct3 plus Comparator flags to
// taken/illegal, and selects signed vs unsigned compare.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       lt,
  output logic       taken,
  output logic       illegal,
  output logic       cmp_s
);

  // funct3[1] distinguishes the unsigned pair (BLTU/BGEU) from the rest.
  assign cmp_s = ~funct3[1];

  always_comb begin
    // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = ~eq;
      BR_BLT:  taken = lt;
      BR_BGE:  taken = ~lt;
      BR_BLTU: taken = lt;
      BR_BGEU: taken = ~lt;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves RV32I conditional branches, issues a held PC redirect and a fixed
// flush. Optional saturating statistics are built when BRANCH_STATS_EN is defined.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic [XLEN-1:0]  br_target,
  output logic             cmp_s,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             resolved_valid,
  output logic             resolved_taken,
  output logic             illegal,
  output logic             misalign,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ack,
  output logic             flush,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_taken
);

  localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

  state_t            state_q, state_d;
  logic              taken_q, illegal_q, misalign_q;
  logic [XLEN-1:0]   target_q;
  logic [FC_W-1:0]   cnt_q;
  logic              cond_taken, cond_illegal;
  logic              handshake;

  branch_cond u_cond (
    .funct3  (br_funct3),
    .eq      (cmp_eq),
    .lt      (cmp_lt),
    .taken   (cond_taken),
    .illegal (cond_illegal),
    .cmp_s   (cmp_s)
  );

  assign handshake = br_valid && br_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
    end
  end

  // Flags are captured on the handshake edge because the Comparator is combinational.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      target_q   <= '0;
    end else if (handshake) begin
      taken_q    <= cond_taken;
      illegal_q  <= cond_illegal;
      misalign_q <= cond_taken && (br_target[1:0] != 2'b00);
      target_q   <= br_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_REDIRECT && redirect_ack) begin
      cnt_q <= FC_LOAD;
    end else if (state_q == S_FLUSH) begin
      cnt_q <= cnt_q - FC_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (handshake) state_d = S_DECIDE;
      S_DECIDE:   state_d = (taken_q && !misalign_q) ? S_REDIRECT : S_IDLE;
      S_REDIRECT: if (redirect_ack) state_d = (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;
      S_FLUSH:    if (cnt_q <= FC_W'(1)) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    br_ready       = (state_q == S_IDLE);
    resolved_valid = (state_q == S_DECIDE);
    resolved_taken = (state_q == S_DECIDE) && taken_q;
    illegal        = (state_q == S_DECIDE) && illegal_q;
    misalign       = (state_q == S_DECIDE) && misalign_q;
    redirect_valid = (state_q == S_REDIRECT);
    redirect_pc    = (state_q == S_REDIRECT) ? target_q : '0;
    flush          = (state_q == S_FLUSH);
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] total_q, taken_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q     <= '0;
      taken_cnt_q <= '0;
    end else if (state_q == S_DECIDE) begin
      if (!illegal_q && total_q != '1)
        total_q <= total_q + CNT_W'(1);
      if (taken_q && !misalign_q && taken_cnt_q != '1)
        taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end

  assign stat_total = total_q;
  assign stat_taken = taken_cnt_q;
`else
  assign stat_total = '0;
  assign stat_taken = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer side of the branch Comparator. Drives the Comparator's signedness select (s) from the branch funct3 and receives its eq/lt flags.
- Decides taken/not-taken for RV32I conditional branches, then issues a held PC redirect to fetch with a valid/ack handshake.
- After the redirect is acknowledged, asserts a fixed-length pipeline flush.
- Sits in stage 2, between the Comparator and the fetch/PC logic.

Parameters:
- XLEN, 32, datapath/PC width.
- FLUSH_CYCLES, 2, number of cycles flush is held after the redirect is acknowledged (0 is legal).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- br_valid  in  1  branch request valid.
- br_ready  out  1  unit can accept a branch.
- br_funct3  in  3  branch funct3.
- br_target  in  XLEN  computed branch target.
- cmp_s  out  1  to Comparator s; 1 = signed compare.
- cmp_eq  in  1  from Comparator eq.
- cmp_lt  in  1  from Comparator lt.
- resolved_valid  out  1  one-cycle pulse: decision available.
- resolved_taken  out  1  decision; valid only when resolved_valid = 1.
- illegal  out  1  one-cycle pulse: funct3 is 010 or 011.
- misalign  out  1  one-cycle pulse: branch taken with target[1:0] != 0.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  XLEN  redirect address.
- redirect_ack  in  1  fetch accepts the redirect.
- flush  out  1  squash younger instructions.
- stat_total  out  CNT_W  branches resolved.
- stat_taken  out  CNT_W  branches taken.

Behaviour:
- Reset (async, rst = 1):
  - State goes to IDLE.
  - br_ready = 1; all other outputs = 0; captured registers = 0; counters = 0.
  - Takes effect mid-operation too: any pending redirect or flush is dropped immediately.
- Comparator select: cmp_s = ~br_funct3[1], combinational.
- Flag sampling: the Comparator is combinational, so cmp_eq/cmp_lt are sampled in the same cycle as the br_valid && br_ready handshake.
- Decode at handshake:
  - 000 BEQ: taken = eq
  - 001 BNE: taken = !eq
  - 100 BLT: taken = lt
  - 101 BGE: taken = !lt
  - 110 BLTU: taken = lt
  - 111 BGEU: taken = !lt
  - 010 or 011: taken = 0 and the illegal flag is set.
- Handshake capture: on br_valid && br_ready, register taken, illegal, misalign (taken && target[1:0] != 0) and br_target.
- FSM (one-hot or encoded, implementer's choice):
  - IDLE: br_ready = 1. On handshake go to DECIDE.
  - DECIDE (cycle N+1 after handshake in cycle N):
    - br_ready = 0; resolved_valid = 1; resolved_taken = captured taken.
    - illegal and misalign pulse here if set.
    - Go to REDIRECT if taken && !misalign; otherwise go to IDLE (br_ready high in N+2).
  - REDIRECT:
    - redirect_valid = 1 and redirect_pc = captured target, both held stable until redirect_ack.
    - On ack, go to FLUSH if FLUSH_CYCLES > 0, else IDLE.
    - An ack in the first REDIRECT cycle is legal.
  - FLUSH:
    - flush = 1 for exactly FLUSH_CYCLES consecutive cycles. A down-counter of width $clog2(FLUSH_CYCLES + 1) is loaded on entry.
    - Then go to IDLE.
- Boundary rules:
  - redirect_ack while not in REDIRECT is ignored.
  - br_valid while br_ready = 0 is ignored; the requester must hold it.
  - Back-to-back not-taken branches: one accepted every 2 cycles.
  - An illegal funct3 never redirects.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - stat_total increments once per DECIDE cycle where illegal = 0.
  - stat_taken increments on DECIDE cycles where taken && !misalign.
  - Both counters saturate at all-ones and do not wrap.
- When undefined: both ports remain in the interface, tied to 0, and no counter flops are built.

Decomposition:
- Package branch_pkg:
  - funct3 localparams: BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU.
  - FSM state encodings: S_IDLE, S_DECIDE, S_REDIRECT, S_FLUSH.
- Sub-module branch_cond: combinational; inputs funct3, eq, lt; outputs taken, illegal, cmp_s.
- The top level holds the FSM, capture registers, flush counter and stats.

Test Plan:
- BEQ, cmp_eq = 1, target 0x0000_1000, redirect_ack held high:
  - N+1: resolved_taken = 1.
  - N+2: redirect_valid = 1, redirect_pc = 0x1000.
  - N+3, N+4: flush = 1.
  - N+5: br_ready = 1.
- BLTU (110), cmp_lt = 0: cmp_s = 0 at handshake; resolved_taken = 0; no redirect; br_ready returns in N+2.
- BGE (101), cmp_lt = 0, target 0x2002: resolved_taken = 1 with a misalign pulse; no redirect_valid.
- funct3 = 011: illegal pulses at N+1; resolved_taken = 0; stat_total unchanged.
- Taken BNE with redirect_ack withheld 5 cycles: redirect_valid and redirect_pc stay constant throughout; flush starts the cycle after ack.
- rst asserted during FLUSH: all outputs drop to 0 asynchronously and br_ready = 1. With BRANCH_STATS_EN, 3 taken and 2 not-taken branches give stat_total = 5 and stat_taken = 3.
